// File: rtl/cache_utils_pkg.sv
// rtl/cache_utils_pkg.sv - shared cache utility types and the line-label width helper
package cache_utils_pkg;

  localparam int ADDR_WIDTH = 32;

  // Stream-buffer controller states (stream_buffer lives beside prefetch_ctrl)
  typedef enum logic [1:0] {
    SB_IDLE,
    SB_FILL,
    SB_VALID
  } sb_state_t;

  // Prefetch controller states
  typedef enum logic [1:0] {
    PF_IDLE,
    PF_WAIT_FILL,
    PF_RESP
  } pf_state_t;

  // How an incoming miss relates to the stream buffer
  typedef enum logic [1:0] {
    CLS_MISS,
    CLS_BUF_HIT,
    CLS_FILL
  } pf_class_t;

  // Line label = byte address minus the offset bits inside one line
  function automatic int label_width(input int line_width);
    return ADDR_WIDTH - $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/prefetch_ctrl.sv
// rtl/prefetch_ctrl.sv - miss handler with single-entry next-line prefetch into a sibling stream_buffer
module prefetch_ctrl
  import cache_utils_pkg::*;
#(
  parameter int  LINE_WIDTH  = 256,
  localparam int LABEL_WIDTH = label_width(LINE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LABEL_WIDTH-1:0] miss_label,
  input  logic                   miss_req,
  output logic                   miss_resp_vld,
  output logic                   miss_hit,
  output logic [LINE_WIDTH-1:0]  miss_line,
  output logic [LABEL_WIDTH-1:0] pf_label,
  output logic                   pf_label_rdy,
  input  logic [LABEL_WIDTH-1:0] sb_label,
  input  logic [LINE_WIDTH-1:0]  sb_data,
  input  logic                   sb_data_vld,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
);

  pf_state_t state;
  pf_state_t state_nxt;
  pf_class_t cls;

  logic                   inflight;
  logic [LABEL_WIDTH-1:0] inflight_label;
  logic                   pend_vld;
  logic [LABEL_WIDTH-1:0] pend_label;
  logic [LABEL_WIDTH-1:0] req_label;
  logic [LABEL_WIDTH-1:0] next_label;
  logic                   classify;
  logic                   fill_done;
  logic                   wait_done;
  logic                   next_known;
  logic                   issue;
  logic                   capture;

  // pf_label_rdy is high exactly in the issue cycle; any data_vld seen then belongs to the previous burst
  assign fill_done  = inflight && !pf_label_rdy && sb_data_vld && (sb_label == inflight_label);
  assign wait_done  = fill_done && (inflight_label == req_label);
  assign classify   = (state == PF_IDLE) && miss_req;
  // Natural wrap of the adder takes the all-ones label to zero
  assign next_label = miss_label + LABEL_WIDTH'(1);
  assign next_known = (inflight && (inflight_label == next_label)) ||
                      (sb_data_vld && (sb_label == next_label));
  // The stream buffer cannot abort a burst, so a new issue waits for inflight to drop
  assign issue      = pend_vld && !inflight;
  // A FILL whose data lands in the very classify cycle is answered directly
  assign capture    = (classify && ((cls == CLS_BUF_HIT) || ((cls == CLS_FILL) && fill_done))) ||
                      ((state == PF_WAIT_FILL) && wait_done);

  // Classify the presented miss against the buffered line and the in-flight burst
  always_comb begin
    cls = CLS_MISS;
    if (!inflight && sb_data_vld && (sb_label == miss_label)) begin
      cls = CLS_BUF_HIT;
    end else if (inflight && (inflight_label == miss_label)) begin
      cls = CLS_FILL;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PF_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      PF_IDLE: begin
        if (miss_req) begin
          if ((cls == CLS_FILL) && !fill_done) begin
            state_nxt = PF_WAIT_FILL;
          end else begin
            state_nxt = PF_RESP;
          end
        end
      end
      PF_WAIT_FILL: begin
        if (wait_done) begin
          state_nxt = PF_RESP;
        end
      end
      PF_RESP:  state_nxt = PF_IDLE;
      default:  state_nxt = PF_IDLE;
    endcase
  end

  // FSM outputs: the response strobe is the single PF_RESP cycle
  always_comb begin
    miss_resp_vld = (state == PF_RESP);
  end

  // Response data path: latch the requested label, capture line data and the hit flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_label <= '0;
      miss_line <= '0;
      miss_hit  <= 1'b0;
    end else begin
      if (classify) begin
        req_label <= miss_label;
      end
      if (capture) begin
        miss_line <= sb_data;
        miss_hit  <= 1'b1;
      end else if (classify) begin
        miss_hit  <= 1'b0;
      end
    end
  end

  // Prefetch tracking: one pending slot (newest wins) and one in-flight burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld       <= 1'b0;
      pend_label     <= '0;
      inflight       <= 1'b0;
      inflight_label <= '0;
      pf_label       <= '0;
      pf_label_rdy   <= 1'b0;
    end else begin
      pf_label_rdy <= issue;
      if (issue) begin
        pf_label       <= pend_label;
        inflight       <= 1'b1;
        inflight_label <= pend_label;
        pend_vld       <= 1'b0;
      end else if (fill_done) begin
        inflight       <= 1'b0;
      end
      // A fresh target overrides both an older pending one and the clear from an issue
      if (classify && !next_known) begin
        pend_vld   <= 1'b1;
        pend_label <= next_label;
      end
    end
  end

  // Response statistics, counted once per response as it retires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == PF_RESP) begin
      if (miss_hit) begin
        hit_cnt  <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: doc/prefetch_ctrl.md
PREFETCH_CTRL -- requirements
Module: prefetch_ctrl

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 256, cache line width in bits.
REQ-002 SHALL have derived localparam LABEL_WIDTH, default 32 - log2(LINE_WIDTH/8) = 27, line label (tag+index) width.
REQ-003 SHALL have port clk  in  1  single clock, all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port miss_label  in  LABEL_WIDTH  label of the cache miss.
REQ-006 SHALL have port miss_req  in  1  miss request, held high until miss_resp_vld.
REQ-007 SHALL have port miss_resp_vld  out  1  one-cycle response strobe.
REQ-008 SHALL have port miss_hit  out  1  1 when miss_line holds the requested line.
REQ-009 SHALL have port miss_line  out  LINE_WIDTH  registered line data.
REQ-010 SHALL have port pf_label  out  LABEL_WIDTH  prefetch label, drives stream_buffer label_i.
REQ-011 SHALL have port pf_label_rdy  out  1  one-cycle prefetch issue, drives stream_buffer label_i_rdy.
REQ-012 SHALL have port sb_label  in  LABEL_WIDTH  stream_buffer label_o.
REQ-013 SHALL have port sb_data  in  LINE_WIDTH  stream_buffer data.
REQ-014 SHALL have port sb_data_vld  in  1  stream_buffer data_vld.
REQ-015 SHALL have ports hit_cnt, miss_cnt  out  32 each  response statistics.

Function
REQ-016 SHALL implement FSM states PF_IDLE, PF_WAIT_FILL, PF_RESP.
REQ-017 SHALL, in PF_IDLE with miss_req=1, register L=miss_label and classify it in that cycle.
REQ-018 SHALL classify BUF_HIT as: inflight=0, sb_data_vld=1, sb_label==L; action: capture sb_data, hit=1, go PF_RESP.
REQ-019 SHALL classify FILL as: inflight=1, inflight_label==L; action: go PF_WAIT_FILL.
REQ-020 SHALL classify every other case as MISS; action: hit=0, go PF_RESP.
REQ-021 SHALL, in PF_WAIT_FILL, go PF_RESP with hit=1 and capture sb_data when fill_done; otherwise hold.
REQ-022 SHALL drive miss_resp_vld=1 for exactly one cycle in PF_RESP, then return to PF_IDLE, ignoring miss_req during PF_RESP.
REQ-023 SHALL give latency miss_req sample to miss_resp_vld of 1 cycle for BUF_HIT/MISS, and fill_done+1 cycle for FILL.
REQ-024 SHALL, on every classification, set pend_label=L+1 (modulo 2^LABEL_WIDTH; all-ones wraps to 0) and pend_vld=1.
REQ-025 SHALL skip REQ-024 when the stream buffer already holds or is fetching L+1.
REQ-026 SHALL use one pending entry, newest target overwriting an older one.
REQ-027 SHALL, when pend_vld=1 and inflight=0, pulse pf_label_rdy for one cycle with pf_label=pend_label.
REQ-028 SHALL, in that issue cycle, clear pend_vld, set inflight=1, and set inflight_label=pend_label.
REQ-029 SHALL define fill_done as: inflight=1, sb_data_vld=1, sb_label==inflight_label, evaluated only from the cycle after issue (stale data_vld in the issue cycle ignored).
REQ-030 SHALL clear inflight on fill_done.
REQ-031 SHALL issue a still-pending prefetch on the next cycle when fill_done and pend_vld=1 coincide, never in the same cycle.
REQ-032 SHALL never issue a prefetch while inflight=1, because stream_buffer cannot abort a burst.
REQ-033 SHALL increment hit_cnt on each PF_RESP with hit=1 and miss_cnt on each PF_RESP with hit=0, both wrapping modulo 2^32.

Reset
REQ-034 SHALL, on rst=0, immediately clear state to PF_IDLE plus inflight, pend_vld, miss_resp_vld, miss_hit, pf_label_rdy, hit_cnt and miss_cnt.
REQ-035 SHALL also clear miss_line, pf_label, pend_label and inflight_label to 0 on reset.
REQ-036 SHALL, on reset mid-fill, discard the outstanding request, with no response ever given for it.
REQ-037 SHALL issue no prefetch in the first cycle after reset deassertion.

Structure
REQ-038 SHALL place pf_state_t and the LABEL_WIDTH derivation in the shared cache-utils package beside sb_state_t.
REQ-039 SHALL contain no sub-module; stream_buffer is instantiated as a sibling at the parent level.

Verification
REQ-040 SHALL cover cold miss L=0x100 after reset: MISS resp 1 cycle later, hit=0, miss_cnt=1; next cycle pf_label=0x101 with one-cycle rdy.
REQ-041 SHALL cover a request for L=0x101 while 0x101 is inflight: PF_WAIT_FILL; resp 1 cycle after sb_data_vld&&sb_label==0x101 with miss_line=sb_data and hit=1; prefetch 0x102 issued afterward.
REQ-042 SHALL cover a request for L=0x102 with the buffered line already valid: hit resp after 1 cycle, hit_cnt increments, prefetch 0x103 issued.
REQ-043 SHALL cover wrap-around L=0x7FFFFFF (all ones): pf_label=0x0000000.
REQ-044 SHALL cover two MISSes 0x200 then 0x300 during one inflight fill: only 0x301 issued after fill_done, 0x201 dropped.
REQ-045 SHALL cover rst pulled low during PF_WAIT_FILL: all outputs 0 immediately, no resp after release, counters 0.
